wb_sdram_arbiter: RTL and testbench
===================================

WB_SDRAM_ARBITER -- requirements
Module: wb_sdram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the Wishbone address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning the Wishbone data width (byte selects = DW/8).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the stall cycles allowed before a forced error (range 2..65535).
REQ-004 The block SHALL have port clock, input, 1, the single Wishbone clock (all logic rising-edge).
REQ-005 The block SHALL have port reset_n, input, 1, the reset, asynchronous and active-low.
REQ-006 The block SHALL have port m_adr_i, input, 2*AW, the master addresses; slice [AW-1:0] = master 0 (ibus), [2*AW-1:AW] = master 1 (dbus).
REQ-007 The block SHALL have port m_dat_i, input, 2*DW, the master write data, sliced like m_adr_i.
REQ-008 The block SHALL have port m_sel_i, input, 2*DW/8, the master byte selects, sliced per master.
REQ-009 The block SHALL have ports m_we_i, m_cyc_i and m_stb_i, each input, 2, the per-master write enable, cycle and strobe (bit n = master n).
REQ-010 The block SHALL have port m_dat_o, output, DW, the read data broadcast to both masters.
REQ-011 The block SHALL have ports m_ack_o and m_err_o, each output, 2, the per-master acknowledge and error.
REQ-012 The block SHALL have ports s_adr_o (AW), s_dat_o (DW), s_sel_o (DW/8), s_we_o (1), s_cyc_o (1) and s_stb_o (1), all outputs, the signals to the SDRAM controller slave.
REQ-013 The block SHALL have ports s_dat_i (DW), s_ack_i (1) and s_err_i (1), all inputs, the slave response.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and ABORT, plus a registered grant index gnt and a registered last-served index last.
REQ-015 In IDLE with any m_cyc_i bit high, the FSM SHALL pick a master and go to BUSY on the next edge; s_cyc_o SHALL assert in that cycle (one-cycle arbitration latency).
REQ-016 On a single request, the requester SHALL win; on simultaneous requests, the master != last SHALL win, with last = 1 after reset so master 0 wins first.
REQ-017 In BUSY, gnt SHALL be frozen while m_cyc_i[gnt] = 1, even when the other master requests.
REQ-018 In BUSY, the s_* outputs SHALL be a combinational mux of the granted master's signals, and s_ack_i/s_err_i SHALL route combinationally to bit gnt only; the non-granted ack/err SHALL be 0.
REQ-019 m_dat_o SHALL equal s_dat_i at all times.
REQ-020 When m_cyc_i[gnt] falls in BUSY, the FSM SHALL go to IDLE and set last = gnt; a pending request SHALL be served from IDLE on the following cycle (one dead cycle between owners).
REQ-021 A 16-bit stall counter SHALL increment each BUSY cycle with s_stb_o = 1 and s_ack_i = s_err_i = 0, and SHALL clear on ack, err, or leaving BUSY.
REQ-022 When the stall counter reaches TIMEOUT, the FSM SHALL go to ABORT; in ABORT, m_err_o[gnt] = 1 for exactly one cycle and s_cyc_o = s_stb_o = 0.
REQ-023 After the ABORT cycle, the FSM SHALL go to IDLE, set last = gnt, and drop any late s_ack_i/s_err_i with no master forwarding.
REQ-024 If s_ack_i and the timeout terminal count coincide, the ack SHALL win and the counter SHALL clear.
REQ-025 In IDLE, all s_* outputs and all m_ack_o/m_err_o bits SHALL be 0.

Reset
REQ-026 On reset_n low, the block SHALL asynchronously force state = IDLE, gnt = 0, last = 1 and stall counter = 0, so all outputs are 0.
REQ-027 A reset in BUSY SHALL abort the slave cycle immediately with no ack/err to either master, and arbitration SHALL restart after the synchronous deassertion edge.

Structure
REQ-028 The state encoding and the stall counter width SHALL live in the shared package wb_arb_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the round-robin pick SHALL be a local function.

Verification
REQ-030 Verification SHALL cover: single m1 read, s_ack_i 3 cycles after s_stb_o -> m_ack_o = 2'b10 for 1 cycle with m_dat_o = s_dat_i, and m_ack_o[0] never high.
REQ-031 Verification SHALL cover: both cyc high out of reset -> m0 served first, m1 second, with one IDLE cycle between owners.
REQ-032 Verification SHALL cover: m0 holds cyc across 4 strobed beats while m1 requests -> all 4 beats go to m0 before m1 is granted.
REQ-033 Verification SHALL cover: TIMEOUT = 8 and slave never acks -> after 8 stall cycles, m_err_o = 2'b01 for 1 cycle, s_cyc_o = 0, then IDLE.
REQ-034 Verification SHALL cover: s_ack_i arrives on the terminal-count cycle -> ack is delivered and no err is raised.
REQ-035 Verification SHALL cover: reset_n pulsed low mid-BUSY -> all outputs 0 asynchronously, and the next simultaneous request grants m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone SDRAM arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam int STALL_W = 16;
    typedef logic [STALL_W-1:0] stall_cnt_t;

endpackage

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller slave between ibus (m0) and dbus (m1),
// with a stall watchdog that terminates a hung slave cycle with an error to the owner.
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [2*AW-1:0]     m_adr_i,
    input  logic [2*DW-1:0]     m_dat_i,
    input  logic [2*DW/8-1:0]   m_sel_i,
    input  logic [1:0]          m_we_i,
    input  logic [1:0]          m_cyc_i,
    input  logic [1:0]          m_stb_i,
    output logic [DW-1:0]       m_dat_o,
    output logic [1:0]          m_ack_o,
    output logic [1:0]          m_err_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i
);

    localparam int SW = DW / 8;
    localparam stall_cnt_t TC = stall_cnt_t'(TIMEOUT - 1);

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    stall_cnt_t stall_q, stall_d;

    logic [AW-1:0] g_adr;
    logic [DW-1:0] g_dat;
    logic [SW-1:0] g_sel;
    logic          g_we, g_cyc, g_stb;
    logic          stalling, tc;

    // Lone requester wins; on a tie the master not served last time wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11)
            return ~last;
        return req[1];
    endfunction

    assign g_adr = gnt_q ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
    assign g_dat = gnt_q ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
    assign g_sel = gnt_q ? m_sel_i[2*SW-1:SW] : m_sel_i[SW-1:0];
    assign g_we  = m_we_i[gnt_q];
    assign g_cyc = m_cyc_i[gnt_q];
    assign g_stb = g_cyc & m_stb_i[gnt_q];

    // Terminal count only fires on a genuine stall cycle, so a coincident ack wins.
    assign stalling = g_stb & ~s_ack_i & ~s_err_i;
    assign tc       = stalling && (stall_q == TC);

    assign m_dat_o = s_dat_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        stall_d = stall_q;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = 2'b00;
        m_err_o = 2'b00;

        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (|m_cyc_i) begin
                    gnt_d   = rr_pick(m_cyc_i, last_q);
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                s_sel_o = g_sel;
                s_we_o  = g_we;
                s_cyc_o = g_cyc;
                s_stb_o = g_stb;
                m_ack_o[gnt_q] = s_ack_i;
                m_err_o[gnt_q] = s_err_i;
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = gnt_q;
                    stall_d = '0;
                end else if (s_ack_i || s_err_i) begin
                    stall_d = '0;
                end else if (tc) begin
                    state_d = ST_ABORT;
                    stall_d = '0;
                end else if (g_stb) begin
                    stall_d = stall_q + stall_cnt_t'(1);
                end
            end

            // Slave is cut off here; any late response it produces is never forwarded.
            ST_ABORT: begin
                m_err_o[gnt_q] = 1'b1;
                state_d = ST_IDLE;
                last_d  = gnt_q;
                stall_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                stall_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed scenarios plus random traffic for wb_sdram_arbiter, checked against an ownership model.
module tb_wb_sdram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;
    localparam int BW = AW + DW + SW + 3;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [2*AW-1:0]   m_adr_i;
    logic [2*DW-1:0]   m_dat_i;
    logic [2*SW-1:0]   m_sel_i;
    logic [1:0]        m_we_i, m_cyc_i, m_stb_i;
    logic [DW-1:0]     m_dat_o;
    logic [1:0]        m_ack_o, m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i;

    always #5 clock = ~clock;

    wb_sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: who owns the slave (-1 = nobody), who was served last,
    // how many unanswered strobes in a row, and whether the owner is being cut off.
    int owner = -1;
    int last  = 1;
    int stall = 0;
    bit abrt  = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sbus"}, {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o}, '0);
        chk({tag, "_ack"}, m_ack_o, 2'b00);
        chk({tag, "_err"}, m_err_o, 2'b00);
    endtask

    // One clock: compare every output mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [BW-1:0] es;
        logic [1:0]    ea, ee;
        @(negedge clock);
        es = '0; ea = 2'b00; ee = 2'b00;
        if (reset_n) begin
            if (abrt) begin
                ee[owner] = 1'b1;
            end else if (owner >= 0) begin
                es = {m_adr_i[owner*AW +: AW], m_dat_i[owner*DW +: DW], m_sel_i[owner*SW +: SW],
                      m_we_i[owner], m_cyc_i[owner], m_cyc_i[owner] & m_stb_i[owner]};
                ea[owner] = s_ack_i;
                ee[owner] = s_err_i;
            end
        end
        chk("s_bus", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o}, es);
        chk("m_ack", m_ack_o, ea);
        chk("m_err", m_err_o, ee);
        chk("m_dat", m_dat_o, s_dat_i);
        @(posedge clock);
        if (!reset_n) begin
            owner = -1; last = 1; stall = 0; abrt = 1'b0;
        end else if (abrt) begin
            last = owner; owner = -1; abrt = 1'b0;
        end else if (owner < 0) begin
            if (m_cyc_i != 2'b00) begin
                owner = (m_cyc_i == 2'b11) ? 1 - last : (m_cyc_i[1] ? 1 : 0);
                stall = 0;
            end
        end else if (!m_cyc_i[owner]) begin
            last = owner; owner = -1; stall = 0;
        end else if (s_ack_i || s_err_i) begin
            stall = 0;
        end else if (m_stb_i[owner]) begin
            stall++;
            if (stall == TO) begin
                abrt = 1'b1; stall = 0;
            end
        end
        #1;
    endtask

    task automatic quiet();
        m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    initial begin
        m_adr_i = {$urandom, $urandom};
        m_dat_i = {$urandom, $urandom};
        m_sel_i = 8'hFF;
        m_we_i  = 2'b00;
        s_dat_i = $urandom;
        quiet();

        #2;
        chk_all_zero("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Both request out of reset: m0 first, one dead cycle, then m1.
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        tick();
        s_ack_i = 1'b1;
        #2; chk("tie_m0_first_adr", s_adr_o, m_adr_i[AW-1:0]); chk("tie_m0_ack", m_ack_o, 2'b01);
        tick();
        m_cyc_i = 2'b10; m_stb_i = 2'b10; s_ack_i = 1'b0;
        tick();
        #2; chk("tie_dead_cycle", s_cyc_o, 1'b0);
        tick();
        s_ack_i = 1'b1;
        #2; chk("tie_m1_second_adr", s_adr_o, m_adr_i[2*AW-1:AW]); chk("tie_m1_ack", m_ack_o, 2'b10);
        tick();
        quiet(); tick(); tick();

        // Single m1 read, slave answers three cycles after the strobe.
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b00;
        tick();
        repeat (3) tick();
        s_ack_i = 1'b1; s_dat_i = $urandom;
        #2; chk("m1_read_ack", m_ack_o, 2'b10); chk("m1_read_dat", m_dat_o, s_dat_i);
        tick();
        quiet(); tick(); tick();

        // m0 holds cyc for four beats while m1 waits.
        m_cyc_i = 2'b11; m_stb_i = 2'b01;
        tick();
        for (int b = 0; b < 4; b++) begin
            m_adr_i[AW-1:0] = $urandom; s_ack_i = 1'b1;
            #2; chk("burst_ack_m0", m_ack_o, 2'b01); chk("burst_adr_m0", s_adr_o, m_adr_i[AW-1:0]);
            tick();
        end
        m_cyc_i = 2'b10; m_stb_i = 2'b10; s_ack_i = 1'b0;
        tick(); tick();
        s_ack_i = 1'b1;
        #2; chk("burst_then_m1", s_adr_o, m_adr_i[2*AW-1:AW]);
        tick();
        quiet(); tick(); tick();

        // Slave never answers: eight stalls, one error cycle, then idle with a late ack dropped.
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        repeat (TO) begin
            #2; chk("to_no_early_err", m_err_o, 2'b00);
            tick();
        end
        #2; chk("to_err", m_err_o, 2'b01); chk("to_cyc_low", s_cyc_o, 1'b0); chk("to_stb_low", s_stb_o, 1'b0);
        tick();
        quiet(); s_ack_i = 1'b1;
        #2; chk("to_late_ack_dropped", m_ack_o, 2'b00); chk("to_idle_cyc", s_cyc_o, 1'b0);
        tick();
        quiet(); tick();

        // Ack lands exactly on the terminal-count cycle.
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        repeat (TO - 1) tick();
        s_ack_i = 1'b1;
        #2; chk("tc_ack_wins", m_ack_o, 2'b01); chk("tc_no_err", m_err_o, 2'b00);
        tick();
        s_ack_i = 1'b0;
        #2; chk("tc_still_busy", s_cyc_o, 1'b1); chk("tc_no_err_after", m_err_o, 2'b00);
        tick();
        quiet(); tick(); tick();

        // Reset pulsed mid-BUSY, then a tie must go to m0.
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        tick(); tick();
        s_ack_i = 1'b1;
        #2; reset_n = 1'b0;
        #1; chk_all_zero("async_rst");
        tick();
        reset_n = 1'b1; s_ack_i = 1'b0;
        tick();
        #2; chk("rst_regrant_m0", s_adr_o, m_adr_i[AW-1:0]); chk("rst_regrant_cyc", s_cyc_o, 1'b1);
        tick();
        quiet(); tick(); tick();

        // Random traffic: first a responsive slave, then a sluggish one that trips the watchdog.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                for (int m = 0; m < 2; m++)
                    if ($urandom_range(7) == 0) m_cyc_i[m] = ~m_cyc_i[m];
                m_stb_i = 2'($urandom);
                m_we_i  = 2'($urandom);
                m_adr_i = {$urandom, $urandom};
                m_dat_i = {$urandom, $urandom};
                m_sel_i = 8'($urandom);
                s_dat_i = $urandom;
                s_ack_i = ($urandom_range(ph == 0 ? 2 : 12) == 0);
                s_err_i = ($urandom_range(15) == 0);
                reset_n = ($urandom_range(299) != 0);
                tick();
            end
            reset_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
